// File: rtl/mem_req_arbiter_pkg.sv
// Shared CPU definitions for the memory request arbiter:
// owner encoding, access size encoding and default depth.
package mem_req_arbiter_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int OUTSTANDING_DEF = 2;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bus shared by both masters
// and the memory slave port.
interface mem_req_arbiter_if
    import mem_req_arbiter_pkg::*;
();
    logic        req;
    logic        wr;
    size_e       size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit transaction owners, one entry per
// request accepted by the slave and not yet answered.
module owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_dout  = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master (inst/data) arbiter onto one sram-like slave port,
// routing responses back by an in-order owner FIFO.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_req_arbiter_if.slave     inst,
    mem_req_arbiter_if.slave     data,
    mem_req_arbiter_if.master    mem
);
    arb_state_e r_state;
    arb_state_e w_state_nxt;
    owner_e     r_hold_owner;
    owner_e     w_grant;
    logic       w_sel_req;
    logic       w_mem_req;
    logic       w_accept;
    logic       w_pop;
    logic       w_head;
    logic       w_full;
    logic       w_empty;
    logic       r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hold_owner <= OWN_INST;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_hold_owner <= w_grant;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mem_req && !mem.addr_ok) w_state_nxt = ST_HOLD;
            ST_HOLD: if (mem.addr_ok) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant is frozen while a stalled request waits for addr_ok.
    always_comb begin
        if (r_state == ST_HOLD) begin
            w_grant = r_hold_owner;
        end else if (data.req) begin
            w_grant = OWN_DATA;
        end else begin
            w_grant = OWN_INST;
        end
        w_sel_req = (w_grant == OWN_DATA) ? data.req : inst.req;
        w_mem_req = w_sel_req & ~w_full & ~reset;
        mem.req   = w_mem_req;
        if (w_grant == OWN_DATA) begin
            mem.wr    = data.wr;
            mem.size  = data.size;
            mem.addr  = data.addr;
            mem.wstrb = data.wstrb;
            mem.wdata = data.wdata;
        end else begin
            mem.wr    = inst.wr;
            mem.size  = inst.size;
            mem.addr  = inst.addr;
            mem.wstrb = inst.wstrb;
            mem.wdata = inst.wdata;
        end
        inst.addr_ok = w_accept & (w_grant == OWN_INST);
        data.addr_ok = w_accept & (w_grant == OWN_DATA);
    end

    assign w_accept     = w_mem_req & mem.addr_ok;
    assign w_pop        = mem.data_ok & ~w_empty;
    assign inst.data_ok = w_pop & (w_head == OWN_INST);
    assign data.data_ok = w_pop & (w_head == OWN_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    // A response with nothing outstanding is a slave protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (mem.data_ok && w_empty) begin
            r_err <= 1'b1;
        end
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios
// plus randomized traffic against a queue-based owner model.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int OUT = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_req_arbiter_if inst_bus ();
    mem_req_arbiter_if data_bus ();
    mem_req_arbiter_if mem_bus ();

    mem_req_arbiter #(
        .OUTSTANDING (OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_bus),
        .data  (data_bus),
        .mem   (mem_bus)
    );

    task automatic idle();
        inst_bus.req   = 1'b0;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = SIZE_WORD;
        inst_bus.addr  = '0;
        inst_bus.wstrb = 4'h0;
        inst_bus.wdata = '0;
        data_bus.req   = 1'b0;
        data_bus.wr    = 1'b0;
        data_bus.size  = SIZE_WORD;
        data_bus.addr  = '0;
        data_bus.wstrb = 4'h0;
        data_bus.wdata = '0;
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = '0;
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst_bus.req = 1'b1;
        data_bus.req = 1'b1;
        mem_bus.addr_ok = 1'b1;
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if (mem_bus.req !== 1'b0) begin
            n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_bus.req);
        end
        n_chk++;
        if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b00) begin
            n_err++; $display("FAIL rst_addr_ok: got %b%b want 00", inst_bus.addr_ok, data_bus.addr_ok);
        end
        n_chk++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
            n_err++; $display("FAIL rst_data_ok: got %b%b want 00", inst_bus.data_ok, data_bus.data_ok);
        end
        n_chk++;
        if (dut.r_err !== 1'b0) begin
            n_err++; $display("FAIL rst_err: got %b want 0", dut.r_err);
        end
        next();
        idle();
        reset = 1'b0;
        next();
    endtask

    task automatic test_priority();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1000_0000;
        data_bus.req = 1'b1; data_bus.addr = 32'h2000_0000;
        mem_bus.addr_ok = 1'b1;
        #1;
        n_chk++;
        if ({data_bus.addr_ok, inst_bus.addr_ok} !== 2'b10) begin
            n_err++; $display("FAIL prio_addr_ok: got d%b i%b want d1 i0", data_bus.addr_ok, inst_bus.addr_ok);
        end
        n_chk++;
        if (mem_bus.addr !== 32'h2000_0000) begin
            n_err++; $display("FAIL prio_addr: got %h want 20000000", mem_bus.addr);
        end
        next();
        data_bus.req = 1'b0;
        #1;
        n_chk++;
        if ({inst_bus.addr_ok, mem_bus.addr} !== {1'b1, 32'h1000_0000}) begin
            n_err++; $display("FAIL prio_inst_next: got ok=%b addr=%h want ok=1 addr=10000000", inst_bus.addr_ok, mem_bus.addr);
        end
        next();
        idle();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h1234_5678;
        #1;
        n_chk++;
        if ({data_bus.data_ok, inst_bus.data_ok, inst_bus.rdata} !== {2'b10, 32'h1234_5678}) begin
            n_err++; $display("FAIL prio_resp0: got d%b i%b rdata=%h want d1 i0 12345678", data_bus.data_ok, inst_bus.data_ok, inst_bus.rdata);
        end
        next();
        #1;
        n_chk++;
        if ({data_bus.data_ok, inst_bus.data_ok} !== 2'b01) begin
            n_err++; $display("FAIL prio_resp1: got d%b i%b want d0 i1", data_bus.data_ok, inst_bus.data_ok);
        end
        next();
        idle();
    endtask

    task automatic test_hold();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0100;
        data_bus.addr = 32'h0000_0200;
        for (int c = 1; c <= 3; c++) begin
            data_bus.req = (c >= 2);
            #1;
            n_chk++;
            if ({mem_bus.req, mem_bus.addr, data_bus.addr_ok} !== {1'b1, 32'h0000_0100, 1'b0}) begin
                n_err++; $display("FAIL hold_c%0d: got req=%b addr=%h dok=%b want 1 00000100 0", c, mem_bus.req, mem_bus.addr, data_bus.addr_ok);
            end
            next();
        end
        mem_bus.addr_ok = 1'b1;
        #1;
        n_chk++;
        if ({inst_bus.addr_ok, data_bus.addr_ok, mem_bus.addr} !== {2'b10, 32'h0000_0100}) begin
            n_err++; $display("FAIL hold_accept: got i%b d%b addr=%h want i1 d0 00000100", inst_bus.addr_ok, data_bus.addr_ok, mem_bus.addr);
        end
        next();
        inst_bus.req = 1'b0;
        #1;
        n_chk++;
        if ({data_bus.addr_ok, mem_bus.addr} !== {1'b1, 32'h0000_0200}) begin
            n_err++; $display("FAIL hold_data_after: got ok=%b addr=%h want 1 00000200", data_bus.addr_ok, mem_bus.addr);
        end
        next();
        idle();
        mem_bus.data_ok = 1'b1;
        next();
        next();
        idle();
    endtask

    task automatic test_response();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1c00_0000;
        mem_bus.addr_ok = 1'b1;
        #1;
        n_chk++;
        if (inst_bus.addr_ok !== 1'b1) begin
            n_err++; $display("FAIL resp_inst_acc: got %b want 1", inst_bus.addr_ok);
        end
        next();
        inst_bus.req = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_1004;
        #1;
        n_chk++;
        if ({data_bus.addr_ok, mem_bus.addr} !== {1'b1, 32'h0000_1004}) begin
            n_err++; $display("FAIL resp_data_acc: got ok=%b addr=%h want 1 00001004", data_bus.addr_ok, mem_bus.addr);
        end
        next();
        idle();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hAAAA_0000;
        #1;
        n_chk++;
        if ({inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata} !== {2'b10, 32'hAAAA_0000}) begin
            n_err++; $display("FAIL resp_first: got i%b d%b rdata=%h want i1 d0 aaaa0000", inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata);
        end
        next();
        mem_bus.rdata = 32'h5555_FFFF;
        #1;
        n_chk++;
        if ({inst_bus.data_ok, data_bus.data_ok, data_bus.rdata} !== {2'b01, 32'h5555_FFFF}) begin
            n_err++; $display("FAIL resp_second: got i%b d%b rdata=%h want i0 d1 5555ffff", inst_bus.data_ok, data_bus.data_ok, data_bus.rdata);
        end
        next();
        idle();
    endtask

    task automatic test_full();
        mem_bus.addr_ok = 1'b1;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0010;
        next();
        inst_bus.req = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_0020;
        next();
        data_bus.req = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0030;
        #1;
        n_chk++;
        if ({mem_bus.req, inst_bus.addr_ok} !== 2'b00) begin
            n_err++; $display("FAIL full_block: got req=%b ok=%b want 0 0", mem_bus.req, inst_bus.addr_ok);
        end
        next();
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if ({mem_bus.req, inst_bus.addr_ok, inst_bus.data_ok} !== 3'b001) begin
            n_err++; $display("FAIL full_pop_cycle: got req=%b aok=%b dok=%b want 0 0 1", mem_bus.req, inst_bus.addr_ok, inst_bus.data_ok);
        end
        next();
        mem_bus.data_ok = 1'b0;
        #1;
        n_chk++;
        if ({inst_bus.addr_ok, mem_bus.addr} !== {1'b1, 32'h0000_0030}) begin
            n_err++; $display("FAIL full_resume: got ok=%b addr=%h want 1 00000030", inst_bus.addr_ok, mem_bus.addr);
        end
        next();
        idle();
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if ({data_bus.data_ok, inst_bus.data_ok} !== 2'b10) begin
            n_err++; $display("FAIL full_order0: got d%b i%b want d1 i0", data_bus.data_ok, inst_bus.data_ok);
        end
        next();
        #1;
        n_chk++;
        if ({data_bus.data_ok, inst_bus.data_ok} !== 2'b01) begin
            n_err++; $display("FAIL full_order1: got d%b i%b want d0 i1", data_bus.data_ok, inst_bus.data_ok);
        end
        next();
        idle();
    endtask

    task automatic test_push_pop();
        mem_bus.addr_ok = 1'b1;
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_0040;
        next();
        data_bus.req = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0050;
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if ({inst_bus.addr_ok, data_bus.data_ok, inst_bus.data_ok} !== 3'b110) begin
            n_err++; $display("FAIL pp_same_cycle: got aok=%b ddok=%b idok=%b want 1 1 0", inst_bus.addr_ok, data_bus.data_ok, inst_bus.data_ok);
        end
        next();
        idle();
        #1;
        n_chk++;
        if (dut.u_fifo.r_cnt !== 2'd1) begin
            n_err++; $display("FAIL pp_occupancy: got %0d want 1", dut.u_fifo.r_cnt);
        end
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b10) begin
            n_err++; $display("FAIL pp_tail_owner: got i%b d%b want i1 d0", inst_bus.data_ok, data_bus.data_ok);
        end
        next();
        idle();
    endtask

    task automatic test_random();
        bit          q[$];
        bit          held = 1'b0;
        bit          hold_own = 1'b0;
        bit          ipend = 1'b0;
        bit          dpend = 1'b0;
        logic [31:0] iaddr = '0;
        logic [31:0] daddr = '0;
        bit          iwr = 1'b0;
        bit          dwr = 1'b0;
        bit          own, sel, exp_req, exp_acc, exp_pop, head, done;
        done = 1'b0;
        for (int i = 0; i < 440 && !done; i++) begin
            if (i >= 400 && !ipend && !dpend && q.size() == 0) begin
                done = 1'b1;
            end else begin
                if (i < 400 && !ipend && ($urandom % 2 == 0)) begin
                    ipend = 1'b1; iaddr = $urandom; iwr = 1'($urandom);
                end
                if (i < 400 && !dpend && ($urandom % 2 == 0)) begin
                    dpend = 1'b1; daddr = $urandom; dwr = 1'($urandom);
                end
                inst_bus.req = ipend; inst_bus.addr = iaddr; inst_bus.wr = iwr;
                data_bus.req = dpend; data_bus.addr = daddr; data_bus.wr = dwr;
                mem_bus.addr_ok = (i >= 400) ? 1'b1 : 1'($urandom);
                mem_bus.data_ok = (q.size() > 0) && ((i >= 400) || ($urandom % 3 == 0));
                mem_bus.rdata = $urandom;
                #1;
                own = held ? hold_own : dpend;
                sel = own ? dpend : ipend;
                exp_req = (q.size() < OUT) && sel;
                exp_acc = exp_req && mem_bus.addr_ok;
                exp_pop = mem_bus.data_ok && (q.size() > 0);
                head = (q.size() > 0) ? q[0] : 1'b0;
                n_chk++;
                if (mem_bus.req !== exp_req) begin
                    n_err++; $display("FAIL rnd_mem_req c%0d: got %b want %b", i, mem_bus.req, exp_req);
                end
                if (exp_req) begin
                    n_chk++;
                    if ({mem_bus.addr, mem_bus.wr} !== {(own ? daddr : iaddr), (own ? dwr : iwr)}) begin
                        n_err++; $display("FAIL rnd_mem_addr c%0d: got %h/%b want %h/%b", i, mem_bus.addr, mem_bus.wr, own ? daddr : iaddr, own ? dwr : iwr);
                    end
                end
                n_chk++;
                if ({inst_bus.addr_ok, data_bus.addr_ok} !== {exp_acc && !own, exp_acc && own}) begin
                    n_err++; $display("FAIL rnd_addr_ok c%0d: got i%b d%b want i%b d%b", i, inst_bus.addr_ok, data_bus.addr_ok, exp_acc && !own, exp_acc && own);
                end
                n_chk++;
                if ({inst_bus.data_ok, data_bus.data_ok} !== {exp_pop && !head, exp_pop && head}) begin
                    n_err++; $display("FAIL rnd_data_ok c%0d: got i%b d%b want i%b d%b", i, inst_bus.data_ok, data_bus.data_ok, exp_pop && !head, exp_pop && head);
                end
                n_chk++;
                if ({inst_bus.rdata, data_bus.rdata} !== {mem_bus.rdata, mem_bus.rdata}) begin
                    n_err++; $display("FAIL rnd_rdata c%0d: got %h %h want %h", i, inst_bus.rdata, data_bus.rdata, mem_bus.rdata);
                end
                next();
                if (exp_pop) void'(q.pop_front());
                if (exp_acc) begin
                    q.push_back(own);
                    held = 1'b0;
                    if (own) dpend = 1'b0;
                    else ipend = 1'b0;
                end else if (exp_req) begin
                    held = 1'b1;
                    hold_own = own;
                end
            end
        end
        n_chk++;
        if (!done) begin
            n_err++; $display("FAIL rnd_drain: traffic not drained, q=%0d ipend=%b dpend=%b", q.size(), ipend, dpend);
        end
        idle();
        #1;
        n_chk++;
        if (dut.r_err !== 1'b0) begin
            n_err++; $display("FAIL rnd_err_flag: got %b want 0", dut.r_err);
        end
        next();
    endtask

    task automatic test_reset_mid();
        mem_bus.addr_ok = 1'b1;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0060;
        next();
        inst_bus.req = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_0070;
        next();
        reset = 1'b1;
        inst_bus.req = 1'b1;
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if ({mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok} !== 5'b0) begin
            n_err++; $display("FAIL midrst_outputs: got %b%b%b%b%b want 00000", mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok);
        end
        next();
        idle();
        reset = 1'b0;
        next();
        mem_bus.data_ok = 1'b1;
        #1;
        n_chk++;
        if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
            n_err++; $display("FAIL midrst_stray_resp: got i%b d%b want 00", inst_bus.data_ok, data_bus.data_ok);
        end
        next();
        idle();
        #1;
        n_chk++;
        if (dut.r_err !== 1'b1) begin
            n_err++; $display("FAIL midrst_err_flag: got %b want 1", dut.r_err);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        next();
        test_reset();
        test_priority();
        test_hold();
        test_response();
        test_full();
        test_push_pop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
